// File: rtl/fwperiph_dma_pkg.sv
// Shared DMA definitions: arbiter state encoding, priority width and the
// burst-length-to-beat-count conversion.
package fwperiph_dma_pkg;

    localparam int PRI_W = 2;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } arb_state_e;

    // A length field of zero encodes the maximum burst, 2^bw beats.
    // Supports length fields up to 16 bits wide.
    function automatic logic [16:0] len_to_cnt(input logic [15:0] len, input int unsigned bw);
        if (len == 16'd0) begin
            return 17'd1 << bw;
        end
        return {1'b0, len};
    endfunction

endpackage

// File: rtl/fwperiph_dma_chan_arb_if.sv
// Channel-side request/grant bundle between the per-channel descriptor logic
// (master) and the burst arbiter (slave).
interface fwperiph_dma_chan_arb_if
    import fwperiph_dma_pkg::*;
#(
    parameter int N_CHANNELS = 4,
    parameter int BURST_W    = 8
);
    localparam int CH_W = $clog2(N_CHANNELS);

    logic                          en;
    logic [N_CHANNELS-1:0]         chan_req;
    logic [PRI_W*N_CHANNELS-1:0]   chan_pri;
    logic [BURST_W*N_CHANNELS-1:0] chan_len;
    logic                          beat;
    logic [N_CHANNELS-1:0]         chan_gnt;
    logic [N_CHANNELS-1:0]         chan_done;
    logic                          bus_active;
    logic [CH_W-1:0]               bus_chan;
    logic [BURST_W:0]              beats_left;

    modport master (
        output en, chan_req, chan_pri, chan_len, beat,
        input  chan_gnt, chan_done, bus_active, bus_chan, beats_left
    );

    modport slave (
        input  en, chan_req, chan_pri, chan_len, beat,
        output chan_gnt, chan_done, bus_active, bus_chan, beats_left
    );

endinterface

// File: rtl/fwperiph_dma_rr_pick.sv
// Combinational picker: strict priority, round-robin among equal-priority
// candidates starting just after ptr_i (wrapping).
module fwperiph_dma_rr_pick
    import fwperiph_dma_pkg::*;
#(
    parameter  int N  = 4,
    localparam int CW = $clog2(N)
) (
    input  logic [N-1:0]       elig_i,
    input  logic [PRI_W*N-1:0] pri_i,
    input  logic [CW-1:0]      ptr_i,
    output logic [CW-1:0]      win_o,
    output logic               vld_o
);

    logic [PRI_W-1:0] max_pri;
    logic             found;
    int               idx;

    // Find the top priority among eligible channels, then the first holder of
    // that priority walking forward from the round-robin pointer.
    always_comb begin
        max_pri = '0;
        found   = 1'b0;
        win_o   = '0;
        idx     = 0;
        for (int i = 0; i < N; i++) begin
            if (elig_i[i] && (pri_i[i*PRI_W +: PRI_W] > max_pri)) begin
                max_pri = pri_i[i*PRI_W +: PRI_W];
            end
        end
        for (int k = 1; k <= N; k++) begin
            idx = (int'(ptr_i) + k) % N;
            if (!found && elig_i[idx] && (pri_i[idx*PRI_W +: PRI_W] == max_pri)) begin
                win_o = CW'(idx);
                found = 1'b1;
            end
        end
    end

    // Any eligible channel guarantees a winner at the maximum priority.
    assign vld_o = |elig_i;

endmodule

// File: rtl/fwperiph_dma_chan_arb.sv
// Burst-level arbiter for the shared DMA transfer engine. Grants one channel
// per burst, counts beats and releases the grant on the last beat.
module fwperiph_dma_chan_arb
    import fwperiph_dma_pkg::*;
#(
    parameter int N_CHANNELS = 4,
    parameter int BURST_W    = 8
) (
    input  logic                    clock,
    input  logic                    reset_n,
    fwperiph_dma_chan_arb_if.slave  bus
);

    localparam int CH_W  = $clog2(N_CHANNELS);
    localparam int CNT_W = BURST_W + 1;

    arb_state_e            state_q, state_d;
    logic [CH_W-1:0]       bus_chan_q, bus_chan_d;
    logic [CH_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [N_CHANNELS-1:0] gnt_q, gnt_d;
    logic [N_CHANNELS-1:0] done_q, done_d;
    logic                  active_q, active_d;

    logic [N_CHANNELS-1:0] elig;
    logic [CH_W-1:0]       win;
    logic                  win_vld;
    logic [BURST_W-1:0]    win_len;

    // Disabled arbiter sees no requesters; a burst in flight is unaffected.
    assign elig    = bus.en ? bus.chan_req : '0;
    assign win_len = bus.chan_len[win*BURST_W +: BURST_W];

    fwperiph_dma_rr_pick #(.N(N_CHANNELS)) u_pick (
        .elig_i (elig),
        .pri_i  (bus.chan_pri),
        .ptr_i  (rr_ptr_q),
        .win_o  (win),
        .vld_o  (win_vld)
    );

    // Next-state: arbitrate in IDLE, count beats in BURST. Length and
    // priority are only looked at on the grant cycle.
    always_comb begin
        state_d    = state_q;
        bus_chan_d = bus_chan_q;
        rr_ptr_d   = rr_ptr_q;
        cnt_d      = cnt_q;
        gnt_d      = gnt_q;
        active_d   = active_q;
        done_d     = '0;
        case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    state_d    = ST_BURST;
                    bus_chan_d = win;
                    cnt_d      = CNT_W'(len_to_cnt(16'(win_len), BURST_W));
                    gnt_d      = '0;
                    gnt_d[win] = 1'b1;
                    active_d   = 1'b1;
                end
            end
            ST_BURST: begin
                if (bus.beat) begin
                    if (cnt_q == CNT_W'(1)) begin
                        state_d  = ST_IDLE;
                        gnt_d    = '0;
                        active_d = 1'b0;
                        cnt_d    = '0;
                        done_d   = gnt_q;
                        rr_ptr_d = bus_chan_q;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset parks the pointer so channel 0 wins the first tie.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            bus_chan_q <= '0;
            rr_ptr_q   <= CH_W'(N_CHANNELS - 1);
            cnt_q      <= '0;
            gnt_q      <= '0;
            done_q     <= '0;
            active_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            bus_chan_q <= bus_chan_d;
            rr_ptr_q   <= rr_ptr_d;
            cnt_q      <= cnt_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            active_q   <= active_d;
        end
    end

    assign bus.chan_gnt   = gnt_q;
    assign bus.chan_done  = done_q;
    assign bus.bus_active = active_q;
    assign bus.bus_chan   = bus_chan_q;
    assign bus.beats_left = cnt_q;

endmodule

// File: tb/tb_fwperiph_dma_chan_arb.sv
// Directed bench for the DMA channel burst arbiter (4 channels, 8-bit length).
module tb_fwperiph_dma_chan_arb;

    logic clock;
    logic reset_n;
    int   checks;
    int   errors;
    int   order [5];

    fwperiph_dma_chan_arb_if #(.N_CHANNELS(4), .BURST_W(8)) bus ();

    fwperiph_dma_chan_arb #(.N_CHANNELS(4), .BURST_W(8)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        clock        = 1'b0;
        reset_n      = 1'b0;
        bus.en       = 1'b0;
        bus.chan_req = 4'b0000;
        bus.chan_pri = 8'h00;
        bus.chan_len = 32'h0;
        bus.beat     = 1'b0;
        order        = '{0, 1, 2, 3, 0};

        // Reset state
        #2;
        chk("rst_gnt",    32'(bus.chan_gnt),   32'h0);
        chk("rst_done",   32'(bus.chan_done),  32'h0);
        chk("rst_active", 32'(bus.bus_active), 32'h0);
        chk("rst_chan",   32'(bus.bus_chan),   32'h0);
        chk("rst_left",   32'(bus.beats_left), 32'h0);
        tick();
        reset_n = 1'b1;

        // Equal priority, all requesting, 1-beat bursts: 0,1,2,3,0 with one idle gap
        bus.en       = 1'b1;
        bus.chan_req = 4'b1111;
        bus.chan_len = {4{8'd1}};
        bus.beat     = 1'b1;
        for (int g = 0; g < 5; g++) begin
            tick();
            chk("rr_gnt",  32'(bus.chan_gnt),   32'(1) << order[g]);
            chk("rr_chan", 32'(bus.bus_chan),   32'(order[g]));
            chk("rr_left", 32'(bus.beats_left), 32'h1);
            tick();
            chk("rr_gap_gnt", 32'(bus.chan_gnt),  32'h0);
            chk("rr_done",    32'(bus.chan_done), 32'(1) << order[g]);
            if (g == 4) bus.chan_req = 4'b0000;
        end
        tick();
        chk("rr_idle_gnt",  32'(bus.chan_gnt),  32'h0);
        chk("rr_idle_done", 32'(bus.chan_done), 32'h0);

        // Single requester ch2, len 3, beat every cycle
        bus.chan_req = 4'b0100;
        bus.chan_len = {4{8'd3}};
        tick();
        chk("s_gnt",    32'(bus.chan_gnt),   32'h4);
        chk("s_chan",   32'(bus.bus_chan),   32'h2);
        chk("s_active", 32'(bus.bus_active), 32'h1);
        chk("s_left3",  32'(bus.beats_left), 32'h3);
        tick();
        chk("s_left2",  32'(bus.beats_left), 32'h2);
        tick();
        chk("s_left1",  32'(bus.beats_left), 32'h1);
        chk("s_done0",  32'(bus.chan_done),  32'h0);
        tick();
        chk("s_done",   32'(bus.chan_done),  32'h4);
        chk("s_endgnt", 32'(bus.chan_gnt),   32'h0);
        chk("s_endact", 32'(bus.bus_active), 32'h0);
        chk("s_endleft",32'(bus.beats_left), 32'h0);
        chk("s_holdch", 32'(bus.bus_chan),   32'h2);
        bus.chan_req = 4'b0000;
        tick();
        chk("s_done_once", 32'(bus.chan_done), 32'h0);

        // Strict priority: ch3 (pri 3) beats ch1 (pri 1) until it drops
        bus.chan_pri = 8'hC4;
        bus.chan_req = 4'b1010;
        bus.chan_len = {4{8'd1}};
        for (int r = 0; r < 3; r++) begin
            tick();
            chk("p_gnt3",  32'(bus.chan_gnt),  32'h8);
            tick();
            chk("p_done3", 32'(bus.chan_done), 32'h8);
            if (r == 2) bus.chan_req = 4'b0010;
        end
        tick();
        chk("p_gnt1",  32'(bus.chan_gnt),  32'h2);
        tick();
        chk("p_done1", 32'(bus.chan_done), 32'h2);
        bus.chan_req = 4'b0000;
        bus.chan_pri = 8'h00;

        // Length 0 means 256 beats; input changes mid-burst are ignored
        bus.chan_req = 4'b0001;
        bus.chan_len = {4{8'd0}};
        bus.beat     = 1'b0;
        tick();
        chk("l0_gnt",   32'(bus.chan_gnt),   32'h1);
        chk("l0_left",  32'(bus.beats_left), 32'd256);
        bus.chan_req = 4'b0000;
        bus.chan_len = {4{8'd5}};
        bus.chan_pri = 8'hFF;
        bus.beat     = 1'b1;
        for (int i = 1; i <= 255; i++) begin
            tick();
            chk("l0_count", 32'(bus.beats_left), 32'(256 - i));
        end
        chk("l0_held", 32'(bus.chan_gnt), 32'h1);
        tick();
        chk("l0_done", 32'(bus.chan_done),  32'h1);
        chk("l0_end",  32'(bus.beats_left), 32'h0);
        chk("l0_rel",  32'(bus.chan_gnt),   32'h0);
        bus.beat     = 1'b0;
        bus.chan_pri = 8'h00;

        // en drops after beat 2 of a 4-beat burst
        bus.chan_req = 4'b0001;
        bus.chan_len = {4{8'd4}};
        tick();
        chk("en_gnt",  32'(bus.chan_gnt),   32'h1);
        chk("en_left", 32'(bus.beats_left), 32'h4);
        bus.beat = 1'b1;
        tick();
        tick();
        chk("en_left2", 32'(bus.beats_left), 32'h2);
        bus.en = 1'b0;
        tick();
        chk("en_left1", 32'(bus.beats_left), 32'h1);
        chk("en_held",  32'(bus.chan_gnt),   32'h1);
        tick();
        chk("en_done",  32'(bus.chan_done),  32'h1);
        bus.beat = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("en_block_gnt", 32'(bus.chan_gnt),   32'h0);
            chk("en_block_act", 32'(bus.bus_active), 32'h0);
        end
        bus.en = 1'b1;
        tick();
        chk("en_regnt", 32'(bus.chan_gnt),   32'h1);
        chk("en_releft",32'(bus.beats_left), 32'h4);
        bus.chan_req = 4'b0000;
        bus.beat     = 1'b1;
        tick();
        tick();
        tick();
        tick();
        chk("en_redone", 32'(bus.chan_done), 32'h1);
        bus.beat = 1'b0;

        // Asynchronous reset in the middle of a burst with 5 beats left
        bus.chan_req = 4'b0100;
        bus.chan_len = {4{8'd8}};
        tick();
        chk("ar_gnt", 32'(bus.chan_gnt), 32'h4);
        bus.beat = 1'b1;
        tick();
        tick();
        tick();
        chk("ar_left5", 32'(bus.beats_left), 32'h5);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_gnt0",  32'(bus.chan_gnt),   32'h0);
        chk("ar_done0", 32'(bus.chan_done),  32'h0);
        chk("ar_act0",  32'(bus.bus_active), 32'h0);
        chk("ar_chan0", 32'(bus.bus_chan),   32'h0);
        chk("ar_left0", 32'(bus.beats_left), 32'h0);
        bus.chan_req = 4'b0000;
        tick();
        reset_n = 1'b1;
        tick();
        tick();
        chk("ar_stray_gnt",  32'(bus.chan_gnt),   32'h0);
        chk("ar_stray_left", 32'(bus.beats_left), 32'h0);
        chk("ar_stray_act",  32'(bus.bus_active), 32'h0);
        chk("ar_stray_done", 32'(bus.chan_done),  32'h0);
        bus.chan_req = 4'b1111;
        bus.chan_len = {4{8'd2}};
        bus.beat     = 1'b0;
        tick();
        chk("ar_tie_gnt",  32'(bus.chan_gnt),   32'h1);
        chk("ar_tie_chan", 32'(bus.bus_chan),   32'h0);
        chk("ar_tie_left", 32'(bus.beats_left), 32'h2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fwperiph_dma_chan_arb.md
# fwperiph_dma_chan_arb

Burst-level arbiter that shares the single memory-side transfer engine of the 4-channel DMA among its channels. Each channel presents a request, a 2-bit priority and a burst length. The block grants exactly one channel at a time, counts completed beats, and releases the grant at the end of the burst. Selection is strict priority, with round-robin among channels at equal priority. It sits between the per-channel register/descriptor logic and the shared transfer datapath.

## Interface
- N_CHANNELS, 4, number of requesting channels (2..8)
- BURST_W, 8, width of the burst-length field; length 0 means 2^BURST_W beats
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- en  in  1  global enable; low blocks new grants but never aborts a burst in progress
- chan_req  in  N_CHANNELS  per-channel burst request, level-sensitive
- chan_pri  in  2*N_CHANNELS  per-channel priority, channel i in bits [2i+1:2i]; larger value wins
- chan_len  in  BURST_W*N_CHANNELS  per-channel burst length in beats, channel i in bits [BURST_W*i +: BURST_W]
- beat  in  1  one-cycle strobe from the datapath: one beat of the granted burst completed
- chan_gnt  out  N_CHANNELS  one-hot grant, registered
- chan_done  out  N_CHANNELS  one-cycle pulse on the granted channel's bit when its burst ends
- bus_active  out  1  high while a grant is held
- bus_chan  out  $clog2(N_CHANNELS)  index of the granted channel; holds its last value when idle
- beats_left  out  BURST_W+1  beats remaining in the current burst; 0 when idle

## Operation
- Two-state FSM: IDLE and BURST.
- **IDLE:**
  - Eligible set = chan_req when en=1, else empty.
  - If the set is non-empty, pick the winner: highest chan_pri value, then the first index after rr_ptr (wrapping) among ties.
  - Latch the winner into bus_chan and its length into the counter (0 loads 2^BURST_W). Go to BURST.
- **BURST:**
  - chan_gnt = onehot(bus_chan), bus_active = 1.
  - Each beat decrements beats_left.
  - A beat when beats_left==1 ends the burst:
    - next state IDLE;
    - chan_done[bus_chan] pulses;
    - rr_ptr <= bus_chan.
- Length and priority are sampled only at grant. chan_req, chan_len and chan_pri changes during BURST have no effect.
- A channel that keeps chan_req high after its chan_done competes again in the next arbitration.
- beat in IDLE is ignored.
- en falling during BURST: the burst completes normally, then no grant is issued while en=0.
- Reset (asynchronous, takes effect immediately, mid-burst included):
  - state IDLE, chan_gnt 0, chan_done 0, bus_active 0;
  - bus_chan 0, beats_left 0, rr_ptr N_CHANNELS-1, so channel 0 wins the first tie.

## Timing
- Grant latency: request visible in IDLE at edge k gives chan_gnt/bus_active high after edge k (one cycle).
- End of burst: the last beat sampled at edge m gives, after edge m, chan_gnt=0, bus_active=0, beats_left=0 and chan_done high for exactly that cycle. That cycle is IDLE and arbitrates, so the next grant appears after edge m+1.
- Minimum gap between bursts: one idle cycle. A 1-beat burst therefore occupies 2 cycles per grant.
- All outputs are registered; no combinational path from inputs to outputs.

## Structure
- Shared package fwperiph_dma_pkg holds:
  - the state enum (IDLE, BURST);
  - the priority width constant (2);
  - the function that converts a length to a count (0 → 2^BURST_W).
- One sub-module, fwperiph_dma_rr_pick: a purely combinational picker. Inputs are the eligible mask, the packed priorities and rr_ptr; outputs are the winner index and a valid bit. It is reused by the future descriptor-fetch arbiter.

## Test plan
- Single requester: chan_req=4'b0100, len=3, beat every cycle → gnt=4'b0100 one cycle after request; beats_left 3,2,1; chan_done[2] pulse after the 3rd beat.
- Equal priority, all four requesting continuously, len=1 → grant order 0,1,2,3,0; each grant followed by exactly one idle cycle.
- Priority: ch1 pri=1, ch3 pri=3, both requesting → ch3 always wins; ch1 is granted only after ch3 drops req.
- Length 0 with BURST_W=8 → grant held for exactly 256 beats; beats_left starts at 256.
- en deasserted mid-burst (len=4, after beat 2) → burst finishes all 4 beats with done pulse; no new grant until en=1, then grant one cycle later.
- reset_n low during BURST with beats_left=5 → all outputs zero immediately. After release, ch0 wins a 4-way tie first, and stray beat strobes while IDLE change nothing.
